// File: rtl/lfsr_checker.sv
// Serial PRBS checker: acquires an N-bit history, verifies predictions, then
// free-runs its own predictor (flywheel) while counting line errors.
module lfsr_checker #(
  parameter int unsigned       N        = 26,
  parameter logic [N-1:0]      TAPS     = 26'h3880000,
  parameter int unsigned       LOCK_CNT = 32,
  parameter int unsigned       LOSS_CNT = 8
) (
  input  logic        clk,
  input  logic        r,
  input  logic        din,
  input  logic        din_valid,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic        lost_pulse,
  output logic [15:0] err_cnt,
  output logic [31:0] bit_cnt
);

  localparam int unsigned FW = $clog2(N + 1);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);

  localparam logic [1:0] ST_ACQ = 2'd0;
  localparam logic [1:0] ST_VER = 2'd1;
  localparam logic [1:0] ST_LCK = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] miss_q, miss_d;
  logic          locked_q, locked_d;
  logic          err_pulse_q, err_pulse_d;
  logic          lost_pulse_q, lost_pulse_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [31:0]   bit_cnt_q, bit_cnt_d;
  logic          pred_c;

  assign pred_c = ^(hist_q & TAPS);

  // Next-state: nothing moves on edges without a valid bit, except the counter clear.
  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    fill_d       = fill_q;
    match_d      = match_q;
    miss_d       = miss_q;
    locked_d     = locked_q;
    err_pulse_d  = 1'b0;
    lost_pulse_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    bit_cnt_d    = bit_cnt_q;

    if (din_valid) begin
      case (state_q)
        ST_ACQ: begin
          hist_d = {hist_q[N-2:0], din};
          if (fill_q == FW'(N - 1)) begin
            state_d = ST_VER;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
        ST_VER: begin
          hist_d = {hist_q[N-2:0], din};
          if ((din == pred_c) && (hist_q != '0)) begin
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d  = ST_LCK;
              locked_d = 1'b1;
              match_d  = '0;
              miss_d   = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LCK: begin
          // Flywheel: the history follows the predictor so one line error counts once.
          hist_d = {hist_q[N-2:0], pred_c};
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 32'd1;
          if (din != pred_c) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
            if (miss_q == LW'(LOSS_CNT - 1)) begin
              state_d      = ST_ACQ;
              fill_d       = '0;
              miss_d       = '0;
              locked_d     = 1'b0;
              lost_pulse_d = 1'b1;
            end else begin
              miss_d = miss_q + LW'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d  = ST_ACQ;
          fill_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q      <= ST_ACQ;
      hist_q       <= '0;
      fill_q       <= '0;
      match_q      <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      lost_pulse_q <= 1'b0;
      err_cnt_q    <= '0;
      bit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      match_q      <= match_d;
      miss_q       <= miss_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      lost_pulse_q <= lost_pulse_d;
      err_cnt_q    <= err_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign lost_pulse = lost_pulse_q;
  assign err_cnt    = err_cnt_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the acquire/verify/flywheel rules.
module tb_lfsr_checker;

  localparam int unsigned N        = 26;
  localparam logic [N-1:0] TAPS    = 26'h3880000;
  localparam int unsigned LOCK_CNT = 32;
  localparam int unsigned LOSS_CNT = 8;
  localparam int LOCK_BITS = N + LOCK_CNT;

  logic        clk = 1'b0;
  logic        r = 1'b1;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err_pulse, lost_pulse;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  lfsr_checker #(.N(N), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .clk(clk), .r(r), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .lost_pulse(lost_pulse),
    .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: the received-bit history as a plain array, newest at [0].
  int     m_mode;   // 0 acquire, 1 verify, 2 locked
  int     m_fill, m_match, m_miss;
  bit     m_hist [N];
  bit     m_locked, m_ep, m_lp;
  longint m_err, m_bits;

  logic [N-1:0] gen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pred();
    bit p = 1'b0;
    for (int k = 0; k < int'(N); k++) if (TAPS[k]) p ^= m_hist[k];
    return p;
  endfunction

  function automatic bit m_hist_nonzero();
    for (int k = 0; k < int'(N); k++) if (m_hist[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_push(input bit b);
    for (int k = int'(N) - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = b;
  endtask

  task automatic m_reset();
    m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0;
    for (int k = 0; k < int'(N); k++) m_hist[k] = 1'b0;
    m_locked = 0; m_ep = 0; m_lp = 0; m_err = 0; m_bits = 0;
  endtask

  task automatic m_update(input bit d, input bit v, input bit c);
    bit p;
    bit nz;
    m_ep = 0;
    m_lp = 0;
    if (v) begin
      p  = m_pred();
      nz = m_hist_nonzero();
      if (m_mode == 0) begin
        m_push(d);
        m_fill++;
        if (m_fill == int'(N)) begin m_mode = 1; m_fill = 0; m_match = 0; end
      end else if (m_mode == 1) begin
        m_push(d);
        if (d == p && nz) begin
          m_match++;
          if (m_match == int'(LOCK_CNT)) begin
            m_mode = 2; m_locked = 1; m_match = 0; m_miss = 0;
          end
        end else m_match = 0;
      end else begin
        m_push(p);
        if (m_bits < 64'hFFFFFFFF) m_bits++;
        if (d != p) begin
          m_ep = 1;
          if (m_err < 64'hFFFF) m_err++;
          m_miss++;
          if (m_miss == int'(LOSS_CNT)) begin
            m_mode = 0; m_fill = 0; m_miss = 0; m_locked = 0; m_lp = 1;
          end
        end else m_miss = 0;
      end
    end
    if (c) begin m_err = 0; m_bits = 0; end
  endtask

  task automatic chk_outputs(input string ctx);
    chk({ctx, ".locked"},     32'(locked),     32'(m_locked));
    chk({ctx, ".err_pulse"},  32'(err_pulse),  32'(m_ep));
    chk({ctx, ".lost_pulse"}, 32'(lost_pulse), 32'(m_lp));
    chk({ctx, ".err_cnt"},    32'(err_cnt),    32'(m_err));
    chk({ctx, ".bit_cnt"},    bit_cnt,         32'(m_bits));
  endtask

  task automatic step(input bit d, input bit v, input bit c);
    din = d; din_valid = v; clr_cnt = c;
    @(posedge clk);
    m_update(d, v, c);
    #1;
    chk_outputs("step");
  endtask

  task automatic gen_bit(output bit b);
    b   = ^(gen & TAPS);
    gen = {gen[N-2:0], b};
  endtask

  task automatic do_reset(input string ctx);
    r = 1'b1;
    #1;
    m_reset();
    chk_outputs(ctx);
    @(posedge clk);
    #1;
    r = 1'b0;
  endtask

  // Feed the clean stream (optionally with 3-cycle valid gaps) until lock; report the bit count.
  task automatic feed_until_lock(input string tag, input bit gaps);
    bit b;
    int n = 0;
    while (!locked && n < 400) begin
      if (gaps) for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b0);
      gen_bit(b);
      step(b, 1'b1, 1'b0);
      n++;
    end
    chk(tag, 32'(n), 32'(LOCK_BITS));
  endtask

  initial begin
    bit b;
    int pulses;
    int burst;
    bit v, c, f;

    m_reset();
    do_reset("reset");
    gen = 26'h0000001;

    // Clean lock and 1000 error-free bits.
    feed_until_lock("clean_lock_at", 1'b0);
    for (int i = 0; i < 1000; i++) begin gen_bit(b); step(b, 1'b1, 1'b0); end
    chk("clean_err_cnt", 32'(err_cnt), 32'd0);
    chk("clean_bit_cnt", bit_cnt, 32'd1000);

    // Single flipped bit at locked-bit index 100.
    step(1'b0, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 160; i++) begin
      gen_bit(b);
      step(b ^ (i == 100), 1'b1, 1'b0);
      pulses += int'(err_pulse);
    end
    chk("single_pulses", 32'(pulses), 32'd1);
    chk("single_err_cnt", 32'(err_cnt), 32'd1);
    chk("single_locked", 32'(locked), 32'd1);

    // Burst of LOSS_CNT flips drops lock on the last one.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < int'(LOSS_CNT); i++) begin
      gen_bit(b);
      step(~b, 1'b1, 1'b0);
      if (i == int'(LOSS_CNT) - 2) chk("burst_held", 32'(locked), 32'd1);
    end
    chk("burst_err_cnt", 32'(err_cnt), 32'(LOSS_CNT));
    chk("burst_unlocked", 32'(locked), 32'd0);
    chk("burst_lost", 32'(lost_pulse), 32'd1);
    feed_until_lock("burst_relock_at", 1'b0);

    // Constant zero stream never locks.
    do_reset("reset_zero");
    pulses = 0;
    for (int i = 0; i < 200; i++) begin step(1'b0, 1'b1, 1'b0); pulses += int'(locked); end
    chk("zero_never_locked", 32'(pulses), 32'd0);
    chk("zero_err_cnt", 32'(err_cnt), 32'd0);

    // Gapped clean stream still locks after exactly N+LOCK_CNT valid bits.
    do_reset("reset_gap");
    feed_until_lock("gap_lock_at", 1'b1);

    // Reset while locked with five isolated errors.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      gen_bit(b); step(~b, 1'b1, 1'b0);
      for (int j = 0; j < 4; j++) begin gen_bit(b); step(b, 1'b1, 1'b0); end
    end
    chk("pre_reset_err_cnt", 32'(err_cnt), 32'd5);
    do_reset("midreset");
    feed_until_lock("reset_relock_at", 1'b0);

    // Clear coincident with a mismatch.
    gen_bit(b);
    step(~b, 1'b1, 1'b1);
    chk("clr_err_pulse", 32'(err_pulse), 32'd1);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);

    // Randomized traffic: random valid gaps, sparse errors, bursts and clears.
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 199) == 0);
      b = 1'b0;
      f = 1'b0;
      if (v) begin
        gen_bit(b);
        if (burst > 0) begin f = 1'b1; burst--; end
        else if ($urandom_range(0, 99) == 0) f = 1'b1;
        if ($urandom_range(0, 299) == 0) burst = int'($urandom_range(2, 12));
      end
      step(b ^ f, v, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
